// File: rtl/lpc_coeff_unloader.sv
// Streams COUNT coefficients out of scratch memory one word at a time to a
// valid/ready consumer, flagging words whose upper half is not a sign extension.
module lpc_coeff_unloader #(
   parameter logic [11:0] BASE_ADDR    = 12'h00B,
   parameter int          COUNT        = 11,
   parameter int          READ_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic [11:0] readAddr,
   input  logic [31:0] memIn,
   output logic [15:0] coeffOut,
   output logic [3:0]  coeffIndex,
   output logic        coeffValid,
   input  logic        coeffReady,
   output logic        rangeErr,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, ADDR, PRESENT, FINISH} state_t;

   localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);
   localparam logic [3:0] IDX_LAST = 4'(COUNT - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] idx;
   logic [3:0] idx_next;
   logic [1:0] lat_cnt;
   logic [1:0] lat_next;
   logic       capture;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= 4'd0;
         lat_cnt    <= 2'd0;
         coeffOut   <= 16'h0000;
         coeffIndex <= 4'd0;
         rangeErr   <= 1'b0;
      end else begin
         state   <= state_next;
         idx     <= idx_next;
         lat_cnt <= lat_next;
         if (capture) begin
            coeffOut   <= memIn[15:0];
            coeffIndex <= idx;
            rangeErr   <= (memIn[31:16] != {16{memIn[15]}});
         end
      end
   end

   // lat_cnt counts ADDR cycles so the read address is held for the full memory latency
   always_comb begin
      state_next = state;
      idx_next   = idx;
      lat_next   = lat_cnt;
      capture    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               idx_next   = 4'd0;
               lat_next   = 2'd0;
               state_next = ADDR;
            end
         end
         ADDR: begin
            if (lat_cnt == LAT_LAST) begin
               capture    = 1'b1;
               state_next = PRESENT;
            end else begin
               lat_next = lat_cnt + 2'd1;
            end
         end
         PRESENT: begin
            if (coeffReady) begin
               lat_next = 2'd0;
               if (idx != IDX_LAST) begin
                  idx_next   = idx + 4'd1;
                  state_next = ADDR;
               end else begin
                  state_next = FINISH;
               end
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign readAddr   = (state == ADDR) ? (BASE_ADDR + {8'h00, idx}) : 12'h000;
   assign coeffValid = (state == PRESENT);
   assign busy       = (state != IDLE);
   assign done       = (state == FINISH);

endmodule
